// File: rtl/ex_com_buffer.sv
// ex_com_buffer: in-order result queue from the execute ALU stage to commit.
// Each entry holds an op's ROB tag, ALU result, store/AMO data, branch outcome,
// mispredict flag and lr.w reservation request.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   flush             drops every entry; same-cycle push/pop are discarded
//   in_valid/in_ready producer handshake (in_ready = not full)
//   in_*              fields of the executed op
//   out_valid/out_ready commit handshake on the head entry
//   out_*             head entry fields (all zero when empty)
//   count             occupancy
module ex_com_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [TAG_W-1:0]             in_tag,
    input  logic [31:0]                  in_aluout,
    input  logic [31:0]                  in_rs2_data,
    input  logic                         in_branch_update,
    input  logic                         in_branch_taken,
    input  logic                         in_pred_taken,
    input  logic                         in_mem_reserved,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [TAG_W-1:0]             out_tag,
    output logic [31:0]                  out_aluout,
    output logic [31:0]                  out_rs2_data,
    output logic                         out_branch_update,
    output logic                         out_branch_taken,
    output logic                         out_mispredict,
    output logic                         out_mem_reserved,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      aluout;
        logic [31:0]      rs2_data;
        logic             branch_update;
        logic             branch_taken;
        logic             mispredict;
        logic             mem_reserved;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    entry_t           in_entry;
    entry_t           head;
    logic             push;
    logic             pop;

    // Handshakes; push is blocked while full even if a pop frees a slot this cycle.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Mispredict is resolved at push so commit sees a single stored flag.
    always_comb begin
        in_entry               = '0;
        in_entry.tag           = in_tag;
        in_entry.aluout        = in_aluout;
        in_entry.rs2_data      = in_rs2_data;
        in_entry.branch_update = in_branch_update;
        in_entry.branch_taken  = in_branch_taken;
        in_entry.mispredict    = in_branch_update & (in_branch_taken ^ in_pred_taken);
        in_entry.mem_reserved  = in_mem_reserved;
    end

    // Storage, pointers and occupancy; reset beats flush beats push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head presentation, zeroed when empty.
    always_comb begin
        head = '0;
        if (out_valid) begin
            head = mem[rd_ptr];
        end
    end

    assign out_tag           = head.tag;
    assign out_aluout        = head.aluout;
    assign out_rs2_data      = head.rs2_data;
    assign out_branch_update = head.branch_update;
    assign out_branch_taken  = head.branch_taken;
    assign out_mispredict    = head.mispredict;
    assign out_mem_reserved  = head.mem_reserved;

endmodule

// File: tb/tb_ex_com_buffer.sv
// Directed bench for ex_com_buffer: reset, single push, fill/drain, wrap with
// simultaneous push+pop, mispredict encoding, flush and mid-operation reset.
module tb_ex_com_buffer;

    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      in_aluout;
    logic [31:0]      in_rs2_data;
    logic             in_branch_update;
    logic             in_branch_taken;
    logic             in_pred_taken;
    logic             in_mem_reserved;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic [31:0]      out_aluout;
    logic [31:0]      out_rs2_data;
    logic             out_branch_update;
    logic             out_branch_taken;
    logic             out_mispredict;
    logic             out_mem_reserved;
    logic [2:0]       count;

    int tests = 0;
    int fails = 0;

    ex_com_buffer #(.DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .in_aluout(in_aluout), .in_rs2_data(in_rs2_data),
        .in_branch_update(in_branch_update), .in_branch_taken(in_branch_taken),
        .in_pred_taken(in_pred_taken), .in_mem_reserved(in_mem_reserved),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_aluout(out_aluout), .out_rs2_data(out_rs2_data),
        .out_branch_update(out_branch_update), .out_branch_taken(out_branch_taken),
        .out_mispredict(out_mispredict), .out_mem_reserved(out_mem_reserved),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [TAG_W-1:0] t, input logic [31:0] alu);
        in_tag           = t;
        in_aluout        = alu;
        in_rs2_data      = '0;
        in_branch_update = 1'b0;
        in_branch_taken  = 1'b0;
        in_pred_taken    = 1'b0;
        in_mem_reserved  = 1'b0;
    endtask

    task automatic push(input logic [TAG_W-1:0] t, input logic [31:0] alu);
        set_in(t, alu);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_in('0, '0);
        step(); step();
        chk("rst_in_ready",  64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count",     64'(count), 64'd0);
        chk("rst_out_tag",   64'(out_tag), 64'd0);
        chk("rst_out_alu",   64'(out_aluout), 64'd0);
        rst_n = 1'b1;
        step();

        // Single push
        push(5'd3, 32'h0000_0010);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_tag",   64'(out_tag), 64'd3);
        chk("t1_out_alu",   64'(out_aluout), 64'h10);
        chk("t1_count",     64'(count), 64'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t1_drain_count", 64'(count), 64'd0);

        // Fill to full, held 5th op, drain in order
        for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 256));
        chk("t2_in_ready_full", 64'(in_ready), 64'd0);
        chk("t2_count_full",    64'(count), 64'd4);
        set_in(5'd5, 32'h500);
        in_valid = 1'b1;
        step();
        chk("t2_held_count", 64'(count), 64'd4);
        chk("t2_held_head",  64'(out_tag), 64'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t2_order_tag", 64'(out_tag), 64'(i));
            chk("t2_order_alu", 64'(out_aluout), 64'(i * 256));
            step();
        end
        out_ready = 1'b0;
        chk("t2_empty_count", 64'(count), 64'd0);
        chk("t2_empty_valid", 64'(out_valid), 64'd0);
        chk("t2_empty_tag",   64'(out_tag), 64'd0);
        chk("t2_empty_alu",   64'(out_aluout), 64'd0);

        // Steady push+pop at count=2 across pointer wrap
        push(5'd10, 32'hA); push(5'd11, 32'hB);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_in(5'(12 + i), 32'(12 + i));
            in_valid = 1'b1;
            chk("t3_head_tag", 64'(out_tag), 64'(10 + i));
            step();
            chk("t3_count", 64'(count), 64'd2);
        end
        in_valid = 1'b0;
        chk("t3_final_head", 64'(out_tag), 64'd16);
        step();
        chk("t3_last_head", 64'(out_tag), 64'd17);
        chk("t3_last_alu",  64'(out_aluout), 64'd17);
        step();
        out_ready = 1'b0;
        chk("t3_drained", 64'(count), 64'd0);

        // Mispredict encoding
        set_in(5'd1, 32'h1); in_branch_update = 1'b1; in_branch_taken = 1'b1; in_pred_taken = 1'b0;
        in_valid = 1'b1; step();
        set_in(5'd2, 32'h2); in_branch_update = 1'b1; in_branch_taken = 1'b0; in_pred_taken = 1'b0;
        step();
        set_in(5'd3, 32'h3); in_branch_taken = 1'b1; in_rs2_data = 32'hDEAD_BEEF; in_mem_reserved = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t4a_mispredict", 64'(out_mispredict), 64'd1);
        chk("t4a_update",     64'(out_branch_update), 64'd1);
        chk("t4a_taken",      64'(out_branch_taken), 64'd1);
        out_ready = 1'b1; step();
        chk("t4b_mispredict", 64'(out_mispredict), 64'd0);
        chk("t4b_update",     64'(out_branch_update), 64'd1);
        chk("t4b_taken",      64'(out_branch_taken), 64'd0);
        step();
        chk("t4c_mispredict", 64'(out_mispredict), 64'd0);
        chk("t4c_update",     64'(out_branch_update), 64'd0);
        chk("t4c_taken",      64'(out_branch_taken), 64'd1);
        chk("t4c_rs2",        64'(out_rs2_data), 64'hDEAD_BEEF);
        chk("t4c_reserved",   64'(out_mem_reserved), 64'd1);
        step();
        out_ready = 1'b0;
        chk("t4_drained", 64'(count), 64'd0);

        // Flush with simultaneous push and pop
        push(5'd20, 32'h20); push(5'd21, 32'h21); push(5'd22, 32'h22);
        chk("t5_pre_count", 64'(count), 64'd3);
        set_in(5'd7, 32'h7);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("t5_count",     64'(count), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_in_ready",  64'(in_ready), 64'd1);
        chk("t5_out_tag",   64'(out_tag), 64'd0);
        step();
        chk("t5_no_tag7", 64'(out_valid), 64'd0);

        // Mid-operation reset with in_valid asserted
        push(5'd30, 32'h30); push(5'd31, 32'h31);
        chk("t6_pre_count", 64'(count), 64'd2);
        set_in(5'd8, 32'h8);
        rst_n = 1'b0; in_valid = 1'b1;
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        chk("t6_count",     64'(count), 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_in_ready",  64'(in_ready), 64'd1);
        chk("t6_out_tag",   64'(out_tag), 64'd0);
        chk("t6_out_alu",   64'(out_aluout), 64'd0);
        push(5'd9, 32'h99);
        chk("t6_head_tag", 64'(out_tag), 64'd9);
        chk("t6_head_alu", 64'(out_aluout), 64'h99);
        chk("t6_count1",   64'(count), 64'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t6_alone", 64'(count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
